mem_wb_stage: RTL and testbench

//  MEM-stage responder plus MEM/WB pipeline register. Consumes the EX/MEM register outputs
//  (MemRead, MemWrite, Address, WD, WB_M, WR_M), serves word loads/stores from an internal

---
 rtl/mips_pkg.sv | 15 +
 rtl/data_mem_array.sv | 21 ++
 rtl/mem_wb_stage.sv | 119 +++++++++++
 tb/tb_mem_wb_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline widths, MEM-stage FSM encoding and the MEM/WB register layout.
package mips_pkg;
  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WB_CTRL_W  = 2;

  typedef enum logic {IDLE, ACCESS} mem_state_t;

  typedef struct packed {
    logic [WB_CTRL_W-1:0]  wb;
    logic [REG_ADDR_W-1:0] wr;
    logic [WORD_W-1:0]     rdata;
    logic [WORD_W-1:0]     alu;
  } memwb_t;
endpackage

// File: rtl/data_mem_array.sv
// Word-wide data memory: synchronous write, read data registered when re is high.
module data_mem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
    if (re) rdata <= mem_q[idx];
  end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM-stage responder with fixed-latency data memory, upstream stall and MEM/WB register.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LAT   = 2,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [WORD_W-1:0]     Address,
  input  logic [WORD_W-1:0]     WD,
  input  logic [WB_CTRL_W-1:0]  WB_M,
  input  logic [REG_ADDR_W-1:0] WR_M,
  output logic                  Stall_M,
  output logic [WB_CTRL_W-1:0]  WB_W,
  output logic [REG_ADDR_W-1:0] WR_W,
  output logic [WORD_W-1:0]     ReadData_W,
  output logic [WORD_W-1:0]     ALUOut_W,
  output logic [CNTW-1:0]       rd_count,
  output logic [CNTW-1:0]       wr_count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LAT+1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT-1);

  mem_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  memwb_t            memwb_q, memwb_d;
  logic [CNTW-1:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic              req, done, stall;
  logic              mem_we, mem_re;
  logic [WORD_W-1:0] mem_rdata;

  assign req  = MemRead | MemWrite;
  assign done = (state_q == ACCESS) && (cnt_q == '0);

  // Read is launched on the edge entering ACCESS; inputs are frozen by the stall
  // until completion, so the registered word is still current then.
  assign mem_we = done & MemWrite;
  assign mem_re = (state_q == IDLE) & MemRead & ~MemWrite;

  data_mem_array #(.DEPTH(DEPTH)) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (Address[IW+1:2]),
    .wdata (WD),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    memwb_d  = '0;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    stall    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          state_d = ACCESS;
          cnt_d   = CNT_INIT;
        end else begin
          memwb_d.wb  = WB_M;
          memwb_d.wr  = WR_M;
          memwb_d.alu = Address;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d     = IDLE;
          memwb_d.wb  = WB_M;
          memwb_d.wr  = WR_M;
          memwb_d.alu = Address;
          // Store takes priority when both requests are raised.
          if (MemWrite) begin
            if (~&wr_cnt_q) wr_cnt_d = wr_cnt_q + 1'b1;
          end else if (MemRead) begin
            memwb_d.rdata = mem_rdata;
            if (~&rd_cnt_q) rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      memwb_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      memwb_q  <= memwb_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Held low while in reset even if a request is still presented.
  assign Stall_M    = stall & rst_n;
  assign WB_W       = memwb_q.wb;
  assign WR_W       = memwb_q.wr;
  assign ReadData_W = memwb_q.rdata;
  assign ALUOut_W   = memwb_q.alu;
  assign rd_count   = rd_cnt_q;
  assign wr_count   = wr_cnt_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: expected MEM/WB contents queued at drive time, checked per edge.
module tb_mem_wb_stage;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int CNTW  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WD;
  logic [1:0]  WB_M;
  logic [4:0]  WR_M;
  logic        Stall_M;
  logic [1:0]  WB_W;
  logic [4:0]  WR_W;
  logic [31:0] ReadData_W, ALUOut_W;
  logic [CNTW-1:0] rd_count, wr_count;

  always #5 clk = ~clk;

  mem_wb_stage #(.DEPTH(DEPTH), .LAT(LAT), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WD(WD), .WB_M(WB_M), .WR_M(WR_M), .Stall_M(Stall_M),
    .WB_W(WB_W), .WR_W(WR_W), .ReadData_W(ReadData_W), .ALUOut_W(ALUOut_W),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  typedef struct {
    logic [1:0]  wb;
    logic [4:0]  wr;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [15:0] rdc;
    logic [15:0] wrc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [DEPTH];
  logic [15:0] m_rdc, m_wrc;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] wb, input logic [4:0] wr,
                          input logic [31:0] rd, input logic [31:0] alu);
    exp_t e;
    e.wb = wb; e.wr = wr; e.rd = rd; e.alu = alu; e.rdc = m_rdc; e.wrc = m_wrc;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    n_assert++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_WB_W"},       32'(WB_W),     32'(e.wb));
    chk({tag, "_WR_W"},       32'(WR_W),     32'(e.wr));
    chk({tag, "_ReadData_W"}, ReadData_W,    e.rd);
    chk({tag, "_ALUOut_W"},   ALUOut_W,      e.alu);
    chk({tag, "_rd_count"},   32'(rd_count), 32'(e.rdc));
    chk({tag, "_wr_count"},   32'(wr_count), 32'(e.wrc));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_Stall_M"},    32'(Stall_M),  32'd0);
    chk({tag, "_WB_W"},       32'(WB_W),     32'd0);
    chk({tag, "_WR_W"},       32'(WR_W),     32'd0);
    chk({tag, "_ReadData_W"}, ReadData_W,    32'd0);
    chk({tag, "_ALUOut_W"},   ALUOut_W,      32'd0);
    chk({tag, "_rd_count"},   32'(rd_count), 32'd0);
    chk({tag, "_wr_count"},   32'(wr_count), 32'd0);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] wb, input logic [4:0] wreg);
    MemRead = rd; MemWrite = wr; Address = addr; WD = wd; WB_M = wb; WR_M = wreg;
  endtask

  // One full EX/MEM transaction: stall cycles with bubbles, then the completing edge.
  task automatic op(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [1:0] wb, input logic [4:0] wreg);
    logic [31:0] rv;
    int idx;
    @(negedge clk);
    drive(rd, wr, addr, wd, wb, wreg);
    if (rd | wr) begin
      for (int i = 0; i < LAT; i++) begin
        #1 chk({tag, "_stall_hi"}, 32'(Stall_M), 32'd1);
        push_exp(2'b0, 5'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1 pop_cmp({tag, "_bubble"});
      end
    end
    #1 chk({tag, "_stall_lo"}, 32'(Stall_M), 32'd0);
    idx = int'(addr[9:2]);
    rv  = 32'd0;
    if (wr) begin
      mdl[idx] = wd;
      if (m_wrc != 16'hFFFF) m_wrc++;
    end else if (rd) begin
      rv = mdl[idx];
      if (m_rdc != 16'hFFFF) m_rdc++;
    end
    push_exp(wb, wreg, rv, addr);
    @(posedge clk);
    #1 pop_cmp({tag, "_done"});
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
    m_rdc = '0; m_wrc = '0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'b0, 5'd0);
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Non-memory ops pass straight through in one cycle
    op("alu1", 1'b0, 1'b0, 32'h0000_1234, 32'd0, 2'b10, 5'd5);
    op("alu2", 1'b0, 1'b0, 32'hFFFF_FFF3, 32'hFFFF_FFFF, 2'b01, 5'd31);

    // Asynchronous reset in the middle of a cycle clears outputs immediately
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    m_rdc = '0; m_wrc = '0;
    @(negedge clk) rst_n = 1'b1;

    // Store then load at the same word
    op("st10", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 5'd0);
    op("ld10", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 2'b11, 5'd8);

    // Upper index bits alias: 0x400 and 0x000 share word 0
    op("st400", 1'b0, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 2'b00, 5'd0);
    op("ld000", 1'b1, 1'b0, 32'h0000_0002, 32'd0, 2'b11, 5'd3);

    // Reset during ACCESS aborts the store
    op("st20a", 1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 2'b00, 5'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0001, 2'b00, 5'd0);
    #1 chk("abort_stall0", 32'(Stall_M), 32'd1);
    @(posedge clk);
    #1 chk("abort_stall1", 32'(Stall_M), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("abort_rst");
    m_rdc = '0; m_wrc = '0;
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 5'd0);
    rst_n = 1'b1;
    op("ld20", 1'b1, 1'b0, 32'h0000_0020, 32'd0, 2'b01, 5'd4);

    // Read and write together: store wins, no load data, only wr_count moves
    op("rw30", 1'b1, 1'b1, 32'h0000_0030, 32'h0000_0055, 2'b01, 5'd9);
    op("ld30", 1'b1, 1'b0, 32'h0000_0031, 32'd0, 2'b11, 5'd10);

    // Back to a plain ALU op straight after a load
    op("alu3", 1'b0, 1'b0, 32'h8000_0000, 32'd0, 2'b11, 5'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
